source_dose_sequencer: RTL and testbench
========================================

// Module: source_dose_sequencer
// PURPOSE
//   Metering controller for a chip inlet. Opens the inlet valve and runs a
//   3-valve peristaltic pump to push a requested number of strokes of fluid
//   into the chamber/mixer network. Delivers one metered dose per
//   valid/ready request, then reports completion to the run scheduler.
// PARAMETERS
//   VOL_W          8    width of stroke-count request and status
//   PHASE_CYCLES   16   clk cycles each pump phase is held (>=1)
//   SETTLE_CYCLES  64   clk cycles held after the last stroke before done (>=1)
//   PURGE_STROKES  4    waste-path strokes per dose (DOSE_PURGE_EN only, >=1)
// PORTS
//   clk           in   1      system clock
//   rst_n         in   1      asynchronous active-low reset
//   req_valid     in   1      dose request present
//   req_ready     out  1      sequencer can accept a request
//   req_volume    in   VOL_W  strokes to deliver
//   abort         in   1      terminate the current dose
//   inlet_valve   out  1      1 = inlet open
//   pump_valve    out  3      pump valve actuation, 1 = valve closed
//   waste_valve   out  1      1 = waste path open
//   busy          out  1      dose in progress (any state except IDLE)
//   done          out  1      one-cycle completion pulse
//   err           out  1      qualifies done: 1 = dose was aborted
//   strokes_done  out  VOL_W  strokes delivered in current/last dose
// BEHAVIOUR
// - Reset (async, immediate): state IDLE. inlet_valve=0, pump_valve=3'b111,
//   waste_valve=0, busy=0, done=0, err=0, strokes_done=0, req_ready=1.
// - req_ready=1 only in IDLE. Accept on the rising edge with req_valid&&req_ready.
//   On accept: latch req_volume, clear strokes_done.
// - States: IDLE -> PREOPEN -> PUMP -> SETTLE -> [PURGE] -> DONE -> IDLE.
//   PREOPEN: inlet_valve=1, pump_valve=3'b111, held PHASE_CYCLES.
//   PUMP: inlet_valve=1. Phases P0..P5 = 110,100,101,001,011,010, each held
//   PHASE_CYCLES. End of P5 is one stroke: strokes_done += 1. If it equals
//   the latched volume -> SETTLE; otherwise -> P0.
//   SETTLE: inlet_valve=0, pump_valve=3'b111, held SETTLE_CYCLES.
//   DONE: one cycle with done=1 and err per abort status, then IDLE.
// - Volume 0: PREOPEN is skipped. Accept -> DONE on the next edge, err=0,
//   with no valve activity.
// - Latency, with no purge: done is high in cycle
//   PHASE_CYCLES*(1+6N)+SETTLE_CYCLES+1, counted from the accept edge (edge 0).
// - abort:
//   - Sampled only while busy and not in DONE. Ignored in IDLE.
//   - Ignored in the accept cycle.
//   - Next edge: -> DONE with err=1, inlet_valve=0, pump_valve=3'b111,
//     waste_valve=0. strokes_done keeps its value.
//   - If abort arrives in the cycle a stroke completes, the stroke counts,
//     then the abort applies.
// - strokes_done holds its value after DONE until the next accept.
// - The stroke counter cannot wrap: volume is at most 2^VOL_W-1.
// - All outputs are registered.
// CONFIGURATION
//   DOSE_PURGE_EN defined:
//     - PURGE state sits between SETTLE and DONE.
//     - PURGE: waste_valve=1, inlet_valve=0, and PURGE_STROKES pump strokes
//       using the same phase pattern and timing.
//     - Purge strokes do not update strokes_done.
//     - abort during PURGE goes to DONE with err=1.
//     - Volume-0 doses skip PURGE.
//   DOSE_PURGE_EN undefined:
//     - No PURGE state. waste_valve is tied to 0.
// TESTING (PHASE_CYCLES=2, SETTLE_CYCLES=4, PURGE_STROKES=1 unless stated)
// - Reset mid-PUMP -> same cycle: pump_valve=111, inlet_valve=0, busy=0,
//   strokes_done=0.
// - Accept volume 1 -> pump_valve sequence 110,100,101,001,011,010 (2 cycles
//   each); done=1, err=0 at cycle 19; strokes_done=1.
// - Accept volume 3 -> done at cycle 43; strokes_done steps 1,2,3 at cycles
//   14,26,38.
// - Volume 0 -> done at cycle 1, err=0; valves never leave reset values.
// - Volume 5, abort at cycle 20 -> DONE at cycle 21 with err=1, strokes_done=1;
//   abort while IDLE has no effect.
// - DOSE_PURGE_EN, volume 1 -> waste_valve=1 for cycles 19-30; done at cycle 31;
//   strokes_done stays 1.

Source files
------------

// File: rtl/source_dose_sequencer.sv
// source_dose_sequencer: meters N peristaltic strokes through an inlet valve per valid/ready request.
// Optional waste-path purge after each dose is built when DOSE_PURGE_EN is defined.
module source_dose_sequencer #(
  parameter int VOL_W         = 8,
  parameter int PHASE_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int PURGE_STROKES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [VOL_W-1:0] req_volume,
  input  logic             abort,
  output logic             inlet_valve,
  output logic [2:0]       pump_valve,
  output logic             waste_valve,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [VOL_W-1:0] strokes_done
);
  localparam int TMAX = PHASE_CYCLES > SETTLE_CYCLES ? PHASE_CYCLES : SETTLE_CYCLES;
  localparam int TW = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] PH_L = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] ST_L = TW'(SETTLE_CYCLES - 1);
  localparam logic [VOL_W-1:0] ONE = VOL_W'(1);
  typedef enum logic [2:0] {IDLE, PREOPEN, PUMP, SETTLE, PURGE, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] ph_q, ph_d, pat;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [VOL_W-1:0] vol_q, vol_d, str_q, str_d;
  logic abt_q, abt_d, tick, stroke;
  logic ready_q, inlet_q, busy_q, done_q, err_q;
  logic [2:0] pump_q;
`ifdef DOSE_PURGE_EN
  localparam int PW = $clog2(PURGE_STROKES) + 1;
  logic [PW-1:0] pur_q, pur_d;
  logic waste_q;
  assign waste_valve = waste_q;
`else
  assign waste_valve = 1'b0;
`endif
  assign tick = cnt_q == '0;
  assign stroke = tick && ph_q == 3'd5;
  assign pat = ph_q == 3'd0 ? 3'b110 : ph_q == 3'd1 ? 3'b100 : ph_q == 3'd2 ? 3'b101 :
               ph_q == 3'd3 ? 3'b001 : ph_q == 3'd4 ? 3'b011 : 3'b010;
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q - TW'(1);
    vol_d   = vol_q;
    str_d   = str_q;
    abt_d   = abt_q;
`ifdef DOSE_PURGE_EN
    pur_d   = pur_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = PH_L;
        ph_d  = 3'd0;
        if (req_valid) begin
          vol_d   = req_volume;
          str_d   = '0;
          abt_d   = 1'b0;
          state_d = req_volume == '0 ? DONE : PREOPEN;
        end
      end
      PREOPEN: if (tick) begin
        state_d = PUMP;
        cnt_d   = PH_L;
      end
      PUMP: if (tick) begin
        cnt_d = PH_L;
        ph_d  = stroke ? 3'd0 : ph_q + 3'd1;
        if (stroke) begin
          str_d = str_q + ONE;
          if (str_q + ONE == vol_q) begin
            state_d = SETTLE;
            cnt_d   = ST_L;
          end
        end
      end
      SETTLE: if (tick) begin
`ifdef DOSE_PURGE_EN
        state_d = PURGE;
        cnt_d   = PH_L;
        ph_d    = 3'd0;
        pur_d   = '0;
`else
        state_d = DONE;
`endif
      end
`ifdef DOSE_PURGE_EN
      PURGE: if (tick) begin
        cnt_d = PH_L;
        ph_d  = stroke ? 3'd0 : ph_q + 3'd1;
        if (stroke) begin
          if (pur_q == PW'(PURGE_STROKES - 1)) state_d = DONE;
          else pur_d = pur_q + PW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // a stroke completing in the abort cycle has already been counted above
    if (abort && state_q != IDLE && state_q != DONE) begin
      state_d = DONE;
      abt_d   = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= 3'd0;
      cnt_q   <= '0;
      vol_q   <= '0;
      str_q   <= '0;
      abt_q   <= 1'b0;
      ready_q <= 1'b1;
      inlet_q <= 1'b0;
      pump_q  <= 3'b111;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      vol_q   <= vol_d;
      str_q   <= str_d;
      abt_q   <= abt_d;
      ready_q <= state_d == IDLE;
      inlet_q <= state_q == PREOPEN || state_q == PUMP;
      pump_q  <= (state_q == PUMP || state_q == PURGE) ? pat : 3'b111;
      busy_q  <= state_q != IDLE;
      done_q  <= state_q == DONE;
      err_q   <= state_q == DONE && abt_q;
    end
  end
`ifdef DOSE_PURGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pur_q   <= '0;
      waste_q <= 1'b0;
    end else begin
      pur_q   <= pur_d;
      waste_q <= state_q == PURGE;
    end
  end
`endif
  assign req_ready    = ready_q;
  assign inlet_valve  = inlet_q;
  assign pump_valve   = pump_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign strokes_done = str_q;
endmodule

// File: tb/tb_source_dose_sequencer.sv
// tb_source_dose_sequencer: directed and random doses checked against a cycle-timeline model.
module tb_source_dose_sequencer;
  localparam int PC = 2, SC = 4, PS = 1;
`ifdef DOSE_PURGE_EN
  localparam int PG = 1;
`else
  localparam int PG = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, abort = 1'b0;
  logic [7:0] req_volume = '0;
  logic req_ready, inlet_valve, waste_valve, busy, done, err;
  logic [2:0] pump_valve;
  logic [7:0] strokes_done;
  int errs = 0, checks = 0;
  typedef struct {
    logic inl, wst, bsy, dn, er, rdy;
    logic [2:0] pv;
    logic [7:0] sd;
    int d;
  } exp_t;
  source_dose_sequencer #(.VOL_W(8), .PHASE_CYCLES(PC), .SETTLE_CYCLES(SC), .PURGE_STROKES(PS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_volume(req_volume),
    .abort(abort), .inlet_valve(inlet_valve), .pump_valve(pump_valve), .waste_valve(waste_valve),
    .busy(busy), .done(done), .err(err), .strokes_done(strokes_done));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] pat(int p);
    logic [2:0] t [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
    return t[p % 6];
  endfunction
  // expected outputs k cycles after the accept edge, for volume n and abort sampled at edge a (0 = none)
  function automatic exp_t model(int n, int a, int k);
    exp_t m;
    int pe = PC * (1 + 6 * n);
    int d = n == 0 ? 1 : pe + SC + 1 + PG * 6 * PC * PS;
    bit ab = n != 0 && a >= 1 && a < d;
    int lim, s = 0;
    if (ab) d = a + 1;
    m.d = d;
    m.inl = 1'b0; m.pv = 3'b111; m.wst = 1'b0;
    m.bsy = k >= 1 && k <= d; m.dn = k == d; m.er = ab && k == d; m.rdy = k >= d;
    if (n != 0 && k < d) begin
      m.inl = k <= pe;
      if (k > PC && k <= pe) m.pv = pat((k - PC - 1) / PC);
      if (PG == 1 && k > pe + SC) begin
        m.wst = 1'b1;
        m.pv = pat((k - pe - SC - 1) / PC);
      end
    end
    lim = (ab && a < k) ? a : k;
    for (int j = 1; j <= n; j++) if (PC * (1 + 6 * j) <= lim) s++;
    m.sd = 8'(s);
    return m;
  endfunction
  task automatic compare(exp_t m, int k);
    chk($sformatf("inlet@%0d", k), inlet_valve, m.inl);
    chk($sformatf("pump@%0d", k), pump_valve, m.pv);
    chk($sformatf("waste@%0d", k), waste_valve, m.wst);
    chk($sformatf("busy@%0d", k), busy, m.bsy);
    chk($sformatf("done@%0d", k), done, m.dn);
    chk($sformatf("err@%0d", k), err, m.er);
    chk($sformatf("ready@%0d", k), req_ready, m.rdy);
    chk($sformatf("strokes@%0d", k), strokes_done, m.sd);
  endtask
  task automatic dose(int n, int a);
    int d = model(n, a, 0).d;
    req_valid = 1'b1;
    req_volume = 8'(n);
    abort = 1'($urandom);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_volume = 8'($urandom);
    abort = a == 1;
    chk("accept_strokes", strokes_done, 0);
    chk("accept_ready", req_ready, 0);
    for (int k = 1; k <= d + 2; k++) begin
      @(posedge clk); #1;
      compare(model(n, a, k), k);
      abort = k + 1 == a;
    end
    abort = 1'b0;
  endtask
  task automatic idle(int c);
    for (int i = 0; i < c; i++) begin
      abort = 1'($urandom);
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_done", done, 0);
    end
    abort = 1'b0;
  endtask
  initial begin
    #12;
    chk("rst_inlet", inlet_valve, 0);
    chk("rst_pump", pump_valve, 3'b111);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strokes", strokes_done, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    dose(1, 0);
    dose(3, 0);
    dose(0, 0);
    idle(4);
    dose(5, 20);
    idle(2);
    for (int i = 0; i < 25; i++) begin
      int n = $urandom_range(0, 8);
      int a = ($urandom % 3 == 0) ? $urandom_range(1, model(n, 0, 0).d + 1) : 0;
      dose(n, a);
      idle($urandom_range(0, 2));
    end
    req_valid = 1'b1;
    req_volume = 8'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pump", pump_valve, 3'b111);
    chk("midrst_inlet", inlet_valve, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_strokes", strokes_done, 0);
    chk("midrst_ready", req_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
